// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and the master FSM state encoding.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

endpackage

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// Optional watchdog compiled in with AXI4LITE_MASTER_TIMEOUT_EN.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,

  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  state_t state;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      rsp_timeout   <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        // AW and W retire independently; leave once neither is still pending.
        WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      // Watchdog overrides any handshake landing on the expiry edge.
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (state != RSP) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
        if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          rsp_valid     <= 1'b1;
          rsp_resp      <= RESP_SLVERR;
          rsp_rdata     <= '0;
          rsp_timeout   <= 1'b1;
          state         <= RSP;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master with a programmable-latency AXI4-Lite slave.
// Timeout expectations follow AXI4LITE_MASTER_TIMEOUT_EN.
module tb_axi4lite_master;
  import axi4lite_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  axi4lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: readies are combinational after a per-channel wait, responses registered.
  int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, b_lat = 0;
  bit b_never = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit aw_got, w_got, b_armed;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_lat);
  assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_lat);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_lat);
  assign m_axi_rdata   = slv_rdata;
  assign m_axi_rresp   = slv_rresp;
  assign m_axi_bresp   = slv_bresp;

  wire aw_hs = m_axi_awvalid & m_axi_awready;
  wire w_hs  = m_axi_wvalid  & m_axi_wready;
  wire b_hs  = m_axi_bvalid  & m_axi_bready;
  wire ar_hs = m_axi_arvalid & m_axi_arready;
  wire r_hs  = m_axi_rvalid  & m_axi_rready;

  always @(posedge clk) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_armed <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (aw_hs) aw_got <= 1'b1;
      if (w_hs)  w_got  <= 1'b1;
      if (!b_armed && !b_never && (aw_got || aw_hs) && (w_got || w_hs)) begin
        b_armed <= 1'b1;
        if (b_lat == 0) m_axi_bvalid <= 1'b1;
        else            b_cnt <= b_lat;
      end
      if (b_cnt != 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) m_axi_bvalid <= 1'b1;
      end
      if (b_hs) begin
        m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_armed <= 1'b0;
      end
      if (ar_hs) begin
        if (r_lat == 0) m_axi_rvalid <= 1'b1;
        else            r_cnt <= r_lat;
      end
      if (r_cnt != 0) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt == 1) m_axi_rvalid <= 1'b1;
      end
      if (r_hs) m_axi_rvalid <= 1'b0;
    end
  end

  // Handshake tallies and captured payloads, plus a VALID-stability monitor.
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, viol = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic p_rst = 1'b1, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(posedge clk) begin
    if (!reset) begin
      if (aw_hs) begin n_aw <= n_aw + 1; last_awaddr <= m_axi_awaddr; end
      if (w_hs)  begin n_w <= n_w + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb; end
      if (b_hs)  n_b <= n_b + 1;
      if (ar_hs) begin n_ar <= n_ar + 1; last_araddr <= m_axi_araddr; end
      if (r_hs)  n_r <= n_r + 1;
      if (!p_rst && ((p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) ||
                     (p_wv  && !p_wr  && (!m_axi_wvalid  || m_axi_wdata  !== p_wdata))  ||
                     (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_araddr))))
        viol <= viol + 1;
    end
    p_rst <= reset;
    p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awaddr <= m_axi_awaddr;
    p_wv  <= m_axi_wvalid;  p_wr  <= m_axi_wready;  p_wdata  <= m_axi_wdata;
    p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_araddr <= m_axi_araddr;
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int acc);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int i = 0; i < 64 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      check("cmd_accept_wait", 64'h0, 64'h1);
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    if (seen < 0) check({tag, "_rsp_wait"}, 64'h0, 64'h1);
  endtask

  int acc, acc2, seen, h, ba, bw, bb, bar;

  initial begin
    #400000;
    $display("FAIL global_time_limit: got stuck expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'h0);
    check("rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'h0);
    check("rst_rdata", 64'(rsp_rdata), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'h1);

    // Zero-wait write: accept cycle counts as the first, rsp_valid is up in the third.
    slv_bresp = RESP_EXOKAY;
    do_cmd(1'b1, 32'h40, 32'h1111_2222, 4'h3, acc);
    wait_rsp("wr0", 20, seen);
    check("wr0_latency", 64'(seen - acc), 64'd2);
    check("wr0_resp", 64'(rsp_resp), 64'(RESP_EXOKAY));
    @(negedge clk);

    // Zero-wait read.
    slv_rresp = RESP_DECERR; slv_rdata = 32'hA5A5_0001;
    do_cmd(1'b0, 32'h44, 32'h0, 4'h0, acc);
    wait_rsp("rd0", 20, seen);
    check("rd0_latency", 64'(seen - acc), 64'd2);
    check("rd0_resp", 64'(rsp_resp), 64'(RESP_DECERR));
    check("rd0_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    @(negedge clk);

    // Read with rvalid two cycles after arready.
    slv_rresp = RESP_OKAY; slv_rdata = 32'h1234_5678; r_lat = 2;
    do_cmd(1'b0, 32'h24, 32'h0, 4'h0, acc);
    wait_rsp("rd1", 20, seen);
    check("rd1_araddr", 64'(last_araddr), 64'h24);
    check("rd1_rdata", 64'(rsp_rdata), 64'h1234_5678);
    check("rd1_resp", 64'(rsp_resp), 64'(RESP_OKAY));
    check("rd1_timeout", 64'(rsp_timeout), 64'h0);
    @(negedge clk);
    r_lat = 0;

    // Write, AW before W.
    ba = n_aw; bw = n_w; bb = n_b;
    slv_bresp = RESP_OKAY; aw_lat = 1; w_lat = 3;
    do_cmd(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, acc);
    wait_rsp("wr1", 20, seen);
    check("wr1_aw_count", 64'(n_aw - ba), 64'd1);
    check("wr1_w_count", 64'(n_w - bw), 64'd1);
    check("wr1_awaddr", 64'(last_awaddr), 64'h20);
    check("wr1_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
    check("wr1_wstrb", 64'(last_wstrb), 64'hF);
    check("wr1_resp", 64'(rsp_resp), 64'(RESP_OKAY));
    check("wr1_rdata_zero", 64'(rsp_rdata), 64'h0);
    @(negedge clk);

    // Write, W before AW.
    ba = n_aw; bw = n_w; bb = n_b;
    aw_lat = 4; w_lat = 1;
    do_cmd(1'b1, 32'h28, 32'h0BAD_CAFE, 4'h5, acc);
    wait_rsp("wr2", 20, seen);
    repeat (4) @(negedge clk);
    check("wr2_w_count", 64'(n_w - bw), 64'd1);
    check("wr2_aw_count", 64'(n_aw - ba), 64'd1);
    check("wr2_b_count", 64'(n_b - bb), 64'd1);
    check("wr2_wdata", 64'(last_wdata), 64'h0BAD_CAFE);
    check("wr2_no_extra_rsp", 64'(rsp_valid), 64'h0);
    aw_lat = 0; w_lat = 0;

    // Back-to-back writes with cmd_valid held.
    do_cmd(1'b1, 32'h50, 32'h5, 4'hF, acc);
    do_cmd(1'b1, 32'h54, 32'h6, 4'hF, acc2);
    check("b2b_spacing", 64'(acc2 - acc), 64'd4);
    wait_rsp("b2b", 20, seen);
    check("b2b_awaddr", 64'(last_awaddr), 64'h54);
    @(negedge clk);

    // Response backpressure with a new command waiting.
    rsp_ready = 1'b0; slv_rdata = 32'h0BAD_F00D;
    do_cmd(1'b0, 32'h30, 32'h0, 4'h0, acc);
    wait_rsp("bp", 20, seen);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h34;
    bar = n_ar;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
      check("bp_rsp_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
      check("bp_cmd_ready", 64'(cmd_ready), 64'h0);
    end
    check("bp_no_new_ar", 64'(n_ar - bar), 64'd0);
    rsp_ready = 1'b1; h = cyc; slv_rdata = 32'h0000_CAFE;
    do_cmd(1'b0, 32'h34, 32'h0, 4'h0, acc);
    check("bp_accept_after_rsp", 64'(acc - h), 64'd2);
    wait_rsp("bp2", 20, seen);
    check("bp2_rdata", 64'(rsp_rdata), 64'h0000_CAFE);
    check("bp2_araddr", 64'(last_araddr), 64'h34);
    @(negedge clk);

    // Slave never answers B.
    b_never = 1'b1;
    do_cmd(1'b1, 32'h60, 32'h7, 4'hF, acc);
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    wait_rsp("to", 40, seen);
    check("to_latency", 64'(seen - acc), 64'd16);
    check("to_resp", 64'(rsp_resp), 64'(RESP_SLVERR));
    check("to_flag", 64'(rsp_timeout), 64'h1);
    check("to_bready", 64'(m_axi_bready), 64'h0);
    check("to_rdata", 64'(rsp_rdata), 64'h0);
    @(negedge clk);
    check("to_flag_cleared", 64'(rsp_timeout), 64'h0);
`else
    for (int i = 0; i < 1000; i++) @(negedge clk);
    check("nowd_still_waiting", 64'(rsp_valid), 64'h0);
    check("nowd_bready", 64'(m_axi_bready), 64'h1);
    check("nowd_timeout_flag", 64'(rsp_timeout), 64'h0);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    b_never = 1'b0;
    @(negedge clk);

    // Reset while waiting in RD_DATA.
    r_lat = 20;
    do_cmd(1'b0, 32'h70, 32'h0, 4'h0, acc);
    for (int i = 0; i < 20 && !m_axi_rready; i++) @(negedge clk);
    check("rst_mid_in_rd_data", 64'(m_axi_rready), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'h0);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'h1);
    check("rst_mid_no_rsp", 64'(rsp_valid), 64'h0);

    check("valid_stability", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
